// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: register-access command layer on top of a byte-level SPI slave.
// Define SPI_CTRL_AUTOINC_EN to post-increment reg_addr after every data byte.
module spi_slave_ctrl #(
    parameter int unsigned ADDR_W  = 4,
    parameter logic [7:0]  ID_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              frame_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WRITE,
        S_READ_REQ,
        S_READ_WAIT,
        S_READ
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;

    logic              r_ss_q1;
    logic              r_ss_s;
    logic [1:0]        r_sync_vld;
    logic              r_armed;

    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic [7:0]        r_tx;
    logic              r_we;
    logic              r_ferr;

    logic [6:0]        w_cmd_hi;
    logic              w_cmd_bad;
    logic              w_addr_ld;
    logic              w_addr_inc;
    logic              w_we_set;
    logic              w_ferr_set;
    logic              w_ferr_clr;
    logic              w_rd_ld;
    logic              w_re;
    logic              w_tx_id;

    assign w_cmd_hi  = rx_data[6:0] >> ADDR_W;
    assign w_cmd_bad = |w_cmd_hi;

    // The synchronizer resets to "deselected", so its first two outputs are
    // not real samples; r_armed only arms once ss_s is genuinely seen high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ss_q1    <= 1'b1;
            r_ss_s     <= 1'b1;
            r_sync_vld <= 2'b00;
            r_armed    <= 1'b0;
        end else begin
            r_ss_q1    <= ss;
            r_ss_s     <= r_ss_q1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            if (r_sync_vld[1] && r_ss_s) begin
                r_armed <= 1'b1;
            end else if (r_state == S_IDLE && w_state_nx == S_CMD) begin
                r_armed <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_addr_ld  = 1'b0;
        w_addr_inc = 1'b0;
        w_we_set   = 1'b0;
        w_ferr_set = 1'b0;
        w_ferr_clr = 1'b0;
        w_rd_ld    = 1'b0;
        w_re       = 1'b0;
        if (r_ss_s) begin
            w_state_nx = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_armed) begin
                        w_state_nx = S_CMD;
                    end
                end
                S_CMD: begin
                    if (rx_done) begin
                        if (w_cmd_bad) begin
                            w_ferr_set = 1'b1;
                            w_state_nx = S_IDLE;
                        end else begin
                            w_ferr_clr = 1'b1;
                            w_addr_ld  = 1'b1;
                            w_state_nx = rx_data[7] ? S_READ_REQ : S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (rx_done) begin
                        w_we_set = 1'b1;
                    end
                end
                S_READ_REQ: begin
                    w_re       = 1'b1;
                    w_state_nx = S_READ_WAIT;
                end
                S_READ_WAIT: begin
                    w_rd_ld    = 1'b1;
                    w_state_nx = S_READ;
                end
                S_READ: begin
                    if (rx_done) begin
`ifdef SPI_CTRL_AUTOINC_EN
                        w_addr_inc = 1'b1;
`endif
                        w_state_nx = S_READ_REQ;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
`ifdef SPI_CTRL_AUTOINC_EN
        if (r_we) begin
            w_addr_inc = 1'b1;
        end
`endif
    end

    assign w_tx_id = (w_state_nx == S_IDLE) ||
                     (w_state_nx == S_CMD)  ||
                     (w_state_nx == S_WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= 8'h00;
            r_tx    <= ID_BYTE;
            r_we    <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_we <= w_we_set;
            if (w_we_set) begin
                r_wdata <= rx_data;
            end
            if (w_addr_ld) begin
                r_addr <= rx_data[ADDR_W-1:0];
            end else if (w_addr_inc) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_ferr_set) begin
                r_ferr <= 1'b1;
            end else if (w_ferr_clr) begin
                r_ferr <= 1'b0;
            end
            // Prefetched read byte is held until the next prefetch lands.
            if (w_rd_ld) begin
                r_tx <= reg_rdata;
            end else if (w_tx_id) begin
                r_tx <= ID_BYTE;
            end
        end
    end

    assign tx_data   = r_tx;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign reg_re    = w_re;
    assign busy      = (r_state != S_IDLE);
    assign frame_err = r_ferr;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: directed frames against spi_slave_ctrl with a
// reg_rdata = addr*0x10 register model and a negedge strobe monitor.
module tb_spi_slave_ctrl;

    localparam int AW = 4;
`ifdef SPI_CTRL_AUTOINC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ss;
    logic          rx_done;
    logic [7:0]    rx_data;
    logic [7:0]    tx_data;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic          reg_we;
    logic          reg_re;
    logic [7:0]    reg_rdata = 8'hEE;
    logic          busy;
    logic          frame_err;

    int n_chk  = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int both_cnt = 0;
    logic [AW-1:0] we_addr[$];
    logic [7:0]    we_data[$];
    int we_b;
    int re_b;

    always #5 clk = ~clk;

    spi_slave_ctrl #(
        .ADDR_W (AW),
        .ID_BYTE(8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ss       (ss),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .tx_data  (tx_data),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdata(reg_rdata),
        .busy     (busy),
        .frame_err(frame_err)
    );

    always @(posedge clk) begin
        reg_rdata <= reg_re ? {reg_addr, 4'h0} : 8'hEE;
    end

    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt++;
            we_addr.push_back(reg_addr);
            we_data.push_back(reg_wdata);
        end
        if (reg_re) re_cnt++;
        if (reg_we && reg_re) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        pulse(b);
        tick(15);
    endtask

    task automatic sel(input logic v);
        ss = v;
        tick(4);
    endtask

    task automatic write_frame(input string tag, input logic [7:0] cmd,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [AW-1:0] a0,
                               input logic [AW-1:0] a1);
        sel(1'b0);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_id"}, tx_data, 8'hA5);
        we_b = we_cnt;
        send_byte(cmd);
        send_byte(d0);
        send_byte(d1);
        check({tag, "_we_cnt"}, we_cnt - we_b, 2);
        check({tag, "_a0"}, we_addr[we_b], a0);
        check({tag, "_d0"}, we_data[we_b], d0);
        check({tag, "_a1"}, we_addr[we_b+1], a1);
        check({tag, "_d1"}, we_data[we_b+1], d1);
        check({tag, "_ferr"}, frame_err, 0);
        sel(1'b1);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        ss      = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        tick(2);
        check("rst_tx", tx_data, 8'hA5);
        check("rst_addr", reg_addr, 0);
        check("rst_we", reg_we, 0);
        check("rst_re", reg_re, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        rst = 1'b0;
        tick(4);

        write_frame("w05", 8'h05, 8'hAA, 8'hBB, 4'h5, AUTO ? 4'h6 : 4'h5);
        write_frame("w02", 8'h02, 8'h11, 8'h22, 4'h2, AUTO ? 4'h3 : 4'h2);

        sel(1'b0);
        re_b = re_cnt;
        pulse(8'h8F);
        tick(2);
        check("rd_tx0", tx_data, 8'hF0);
        check("rd_re0", re_cnt - re_b, 1);
        check("rd_addr0", reg_addr, 4'hF);
        tick(13);
        pulse(8'h00);
        tick(2);
        check("rd_tx1", tx_data, AUTO ? 8'h00 : 8'hF0);
        check("rd_re1", re_cnt - re_b, 2);
        check("rd_addr1", reg_addr, AUTO ? 4'h0 : 4'hF);
        tick(13);
        sel(1'b1);
        check("rd_idle", busy, 0);
        check("rd_id", tx_data, 8'hA5);

        sel(1'b0);
        we_b = we_cnt;
        re_b = re_cnt;
        pulse(8'h30);
        tick(1);
        check("bad_ferr", frame_err, 1);
        check("bad_busy", busy, 0);
        tick(14);
        send_byte(8'h11);
        send_byte(8'h82);
        check("bad_no_we", we_cnt - we_b, 0);
        check("bad_no_re", re_cnt - re_b, 0);
        sel(1'b1);
        check("bad_sticky", frame_err, 1);
        sel(1'b0);
        pulse(8'h03);
        tick(1);
        check("bad_clr", frame_err, 0);
        tick(14);
        send_byte(8'h44);
        check("bad_we", we_cnt - we_b, 1);
        check("bad_a", we_addr[we_b], 4'h3);
        check("bad_d", we_data[we_b], 8'h44);
        sel(1'b1);

        sel(1'b0);
        we_b = we_cnt;
        pulse(8'h07);
        tick(1);
        ss = 1'b1;
        tick(4);
        check("abt_busy", busy, 0);
        check("abt_id", tx_data, 8'hA5);
        pulse(8'h66);
        tick(3);
        check("abt_no_we", we_cnt - we_b, 0);

        we_b = we_cnt;
        re_b = re_cnt;
        sel(1'b0);
        sel(1'b1);
        check("empty_ferr", frame_err, 0);
        check("empty_we", we_cnt - we_b, 0);
        check("empty_re", re_cnt - re_b, 0);

        sel(1'b0);
        pulse(8'h85);
        tick(2);
        check("mr_tx", tx_data, 8'h50);
        tick(5);
        #3;
        rst = 1'b1;
        #1;
        check("mr_tx_id", tx_data, 8'hA5);
        check("mr_addr", reg_addr, 0);
        check("mr_wdata", reg_wdata, 0);
        check("mr_we", reg_we, 0);
        check("mr_re", reg_re, 0);
        check("mr_busy", busy, 0);
        check("mr_ferr", frame_err, 0);
        tick(2);
        rst = 1'b0;
        tick(6);
        check("mr_wait", busy, 0);
        sel(1'b1);
        sel(1'b0);
        check("mr_busy2", busy, 1);
        we_b = we_cnt;
        send_byte(8'h01);
        send_byte(8'h77);
        check("mr_we_cnt", we_cnt - we_b, 1);
        check("mr_a", we_addr[we_b], 4'h1);
        check("mr_d", we_data[we_b], 8'h77);
        sel(1'b1);

        check("no_both", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_ctrl.md
SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, register address width (1..7).
REQ-002 Parameter ID_BYTE, default 8'hA5, byte presented on tx_data while idle.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ss  input  1  raw SPI slave-select, active-low, asynchronous to clk.
REQ-006 rx_done  input  1  one-cycle pulse from byte-level SPI slave: rx_data valid.
REQ-007 rx_data  input  8  received byte.
REQ-008 tx_data  output  8  next byte to shift out; wired to SPI slave din.
REQ-009 reg_addr  output  ADDR_W  register bus address.
REQ-010 reg_wdata  output  8  register bus write data.
REQ-011 reg_we  output  1  one-cycle write strobe.
REQ-012 reg_re  output  1  one-cycle read strobe.
REQ-013 reg_rdata  input  8  read data, valid exactly one cycle after reg_re.
REQ-014 busy  output  1  high while a frame is active (FSM not IDLE).
REQ-015 frame_err  output  1  sticky; set on a malformed frame, cleared by the next command byte.

Function
REQ-016 ss SHALL pass through a two-flop synchronizer; all frame logic uses the synchronized ss_s.
REQ-017 FSM states: IDLE, CMD, WRITE, READ_REQ, READ_WAIT, READ.
REQ-018 IDLE -> CMD when ss_s is low; tx_data = ID_BYTE in IDLE and CMD.
REQ-019 In CMD, on rx_done: bit7=1 is read, bit7=0 is write; reg_addr <= rx_data[ADDR_W-1:0].
REQ-020 Command with rx_data[6:ADDR_W] nonzero SHALL set frame_err and go to IDLE-wait: all further bytes are ignored until ss_s is high.
REQ-021 Write command: CMD -> WRITE; each rx_done in WRITE pulses reg_we for one cycle, with reg_wdata = rx_data and the current reg_addr.
REQ-022 Write address update: the cycle after reg_we, reg_addr increments by 1, modulo 2^ADDR_W (wraps from all-ones to 0).
REQ-023 Read command: CMD -> READ_REQ; reg_re pulses the next cycle; READ_WAIT latches reg_rdata into tx_data; -> READ.
REQ-024 tx_data SHALL be updated within 3 clk of the command byte's rx_done; SPI slave byte period is at least 16 clk, so prefetch always completes before the next byte load.
REQ-025 In READ, each rx_done (byte shifted out; MOSI content ignored) increments reg_addr (wrapping), then -> READ_REQ to prefetch the next byte.
REQ-026 ss_s rising in any state SHALL return the FSM to IDLE within 1 cycle; no reg_we/reg_re is issued after that edge.
REQ-027 ss_s rising while in CMD with zero bytes received is legal (empty frame): no error, no strobes.
REQ-028 rx_done while ss_s is high SHALL be ignored.
REQ-029 reg_we and reg_re SHALL never be asserted in the same cycle; at most one strobe per received byte.
REQ-030 busy = (state != IDLE).

Reset
REQ-031 On rst: state=IDLE, tx_data=ID_BYTE, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, frame_err=0, synchronizer flops=1 (deselected).
REQ-032 rst asserted mid-frame SHALL abort immediately without strobes; after release the controller waits for the next ss_s falling edge (ss_s high then low) before accepting a command.

Configuration
REQ-033 Macro SPI_CTRL_AUTOINC_EN: when defined, the address post-increments per REQ-022/REQ-025.
REQ-034 Without SPI_CTRL_AUTOINC_EN, reg_addr holds the command address for the whole frame: repeated writes hit one register; a read streams repeated re-reads of that register (fresh reg_re per byte).

Verification
REQ-035 Write burst: ss low, bytes 0x02,0x11,0x22 -> reg_we at addr 2 with data 0x11, then addr 3 with data 0x22; frame_err=0.
REQ-036 Read burst: ss low, cmd 0x8F, reg_rdata = addr*0x10 -> tx_data 0xF0 before 2nd byte, then 0x00 (wrap) before 3rd byte.
REQ-037 Bad address: cmd 0x30 with ADDR_W=4 -> frame_err=1; subsequent bytes produce no strobes; next valid cmd clears frame_err.
REQ-038 Abort: ss raised 2 cycles after write cmd rx_done -> no reg_we; busy=0 within 4 cycles; tx_data=ID_BYTE.
REQ-039 Async reset mid-read -> all outputs at REQ-031 values in the same cycle; the new frame after an ss high/low cycle works normally.
REQ-040 Macro off: write 0x05,0xAA,0xBB -> two reg_we, both to addr 5.
